// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle sequencer: opcodes, ALU select encodings
// and the 2-bit FSM state encoding.
package ctrl_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_FETCH     = 2'd0,
    ST_DECODE    = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decode: 4-bit opcode to {legal, alu_ctrl}.
// Undefined opcodes report legal = 0 with alu_ctrl forced to ADD.
module opcode_decoder
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       legal,
  output logic [1:0] alu_ctrl
);

  always_comb begin
    legal    = 1'b1;
    alu_ctrl = ALU_ADD;
    case (opcode)
      OP_ADD:  alu_ctrl = ALU_ADD;
      OP_SUB:  alu_ctrl = ALU_SUB;
      OP_AND:  alu_ctrl = ALU_AND;
      OP_OR:   alu_ctrl = ALU_OR;
      default: legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the ALU and register file.
// Define MULTICYCLE_CTRL_PERF_EN to add retired/illegal performance counters.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int RD_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [3:0]      instr_opcode,
  input  logic [RD_W-1:0] instr_rd,
  input  logic            wb_stall,
  output logic            ir_load,
  output logic            alu_en,
  output logic [1:0]      alu_ctrl,
  output logic            reg_write,
  output logic [RD_W-1:0] rf_waddr,
  output logic            pc_inc,
  output logic            illegal,
  output logic            busy
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] illegal_cnt
`endif
);

  generate
    if (CNT_W < 1 || RD_W < 1) begin : g_bad_params
    end
  endgenerate

  state_t          state_reg;
  logic [3:0]      opcode_reg;
  logic [RD_W-1:0] rd_reg;
  logic [1:0]      alu_sel_reg;
  logic            dec_legal;
  logic [1:0]      dec_alu;
  logic            wb_done;

  opcode_decoder u_dec (
    .opcode   (opcode_reg),
    .legal    (dec_legal),
    .alu_ctrl (dec_alu)
  );

  // Reset forces FETCH asynchronously, so every state-derived output drops with it.
  assign instr_ready = (state_reg == ST_FETCH) & ~reset;
  assign ir_load     = instr_valid & instr_ready;
  assign alu_en      = (state_reg == ST_EXECUTE);
  assign busy        = (state_reg != ST_FETCH);
  assign illegal     = (state_reg == ST_DECODE) & ~dec_legal;
  assign wb_done     = (state_reg == ST_WRITEBACK) & ~wb_stall;
  assign reg_write   = wb_done & (rd_reg != '0);
  assign pc_inc      = wb_done | illegal;
  assign alu_ctrl    = alu_sel_reg;
  assign rf_waddr    = rd_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_FETCH;
      opcode_reg  <= '0;
      rd_reg      <= '0;
      alu_sel_reg <= ALU_ADD;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          if (ir_load) begin
            opcode_reg <= instr_opcode;
            rd_reg     <= instr_rd;
            state_reg  <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          // dec_alu is ADD for undefined opcodes, which leaves alu_ctrl at 00.
          alu_sel_reg <= dec_alu;
          state_reg   <= dec_legal ? ST_EXECUTE : ST_FETCH;
        end
        ST_EXECUTE: state_reg <= ST_WRITEBACK;
        ST_WRITEBACK: begin
          if (!wb_stall) state_reg <= ST_FETCH;
        end
        default: state_reg <= ST_FETCH;
      endcase
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_cnt <= '0;
      illegal_cnt <= '0;
    end else begin
      if (wb_done) retired_cnt <= retired_cnt + 1'b1;
      if (illegal) illegal_cnt <= illegal_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl; counter checks are active
// when MULTICYCLE_CTRL_PERF_EN is defined.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] instr_opcode = 4'd0;
  logic [4:0] instr_rd = 5'd0;
  logic       wb_stall = 1'b0;
  logic       ir_load, alu_en, reg_write, pc_inc, illegal, busy;
  logic [1:0] alu_ctrl;
  logic [4:0] rf_waddr;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] retired_cnt, illegal_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.RD_W(5), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_rd     (instr_rd),
    .wb_stall     (wb_stall),
    .ir_load      (ir_load),
    .alu_en       (alu_en),
    .alu_ctrl     (alu_ctrl),
    .reg_write    (reg_write),
    .rf_waddr     (rf_waddr),
    .pc_inc       (pc_inc),
    .illegal      (illegal),
    .busy         (busy)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .retired_cnt  (retired_cnt),
    .illegal_cnt  (illegal_cnt)
`endif
  );

  // Packed outputs: {rdy, ir_load, alu_en, alu_ctrl[1:0], reg_write, rf_waddr[4:0], pc_inc, illegal, busy}
  typedef struct {
    logic        rst;
    logic        vld;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        st;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int rst, int vld, int op, int rd, int st,
                              int rdy, int irl, int ae, int ac, int rw, int wa,
                              int pci, int ill, int bsy);
    vec_t v;
    v.rst = rst[0];
    v.vld = vld[0];
    v.op  = op[3:0];
    v.rd  = rd[4:0];
    v.st  = st[0];
    v.exp = {rdy[0], irl[0], ae[0], ac[1:0], rw[0], wa[4:0], pci[0], ill[0], bsy[0]};
    return v;
  endfunction

  function automatic logic [13:0] outs();
    return {instr_ready, ir_load, alu_en, alu_ctrl, reg_write, rf_waddr, pc_inc, illegal, busy};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] op,
                       input logic [4:0] rd, input logic st);
    reset = r; instr_valid = v; instr_opcode = op; instr_rd = rd; wb_stall = st;
  endtask

  initial begin
    //          rst vld op  rd st | rdy irl ae ac rw wa pci ill bsy
    vecs.push_back(mk(1, 1, 0, 5, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));  // reset holds all low
    vecs.push_back(mk(0, 1, 0, 5, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0));  // ADD rd5 handshake N
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 5, 0, 0, 1));  // DECODE
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 5, 0, 0, 1));  // EXECUTE
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 5, 1, 0, 1));  // WRITEBACK
    vecs.push_back(mk(0, 1, 1, 1, 0,  1, 1, 0, 0, 0, 5, 0, 0, 0));  // SUB rd1 at N+4
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 2, 2, 0,  1, 1, 0, 1, 0, 1, 0, 0, 0));  // AND rd2
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 2, 0, 2, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 2, 1, 2, 1, 0, 1));
    vecs.push_back(mk(0, 1, 3, 3, 0,  1, 1, 0, 2, 0, 2, 0, 0, 0));  // OR rd3
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 2, 0, 3, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 3, 0, 3, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 3, 1, 3, 1, 0, 1));
    vecs.push_back(mk(0, 1, 15, 7, 0, 1, 1, 0, 3, 0, 3, 0, 0, 0));  // illegal opcode 1111
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 3, 0, 7, 1, 1, 1));  // illegal + pc_inc
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 7, 0, 0, 0));  // back in FETCH, alu_ctrl 00
    vecs.push_back(mk(0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 7, 0, 0, 0));  // ADD rd0
    vecs.push_back(mk(0, 1, 15, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));  // valid ignored in DECODE
    vecs.push_back(mk(0, 1, 15, 9, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));  // valid ignored in EXECUTE
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 1));  // rd0: no reg_write, pc_inc
    vecs.push_back(mk(0, 1, 1, 9, 0,  1, 1, 0, 0, 0, 0, 0, 0, 0));  // SUB rd9 with stall
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 9, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 9, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 9, 0, 0, 1));  // stall N+3
    vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 9, 0, 0, 1));  // stall N+4
    vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, 1, 0, 9, 0, 0, 1));  // stall N+5
    vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 9, 1, 0, 1));  // write at N+6
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 9, 0, 0, 0));

    repeat (2) @(negedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].vld, vecs[i].op, vecs[i].rd, vecs[i].st);
      #1;
      checks++;
      if (outs() !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec%0d got=%b exp=%b", i, outs(), vecs[i].exp);
      end else begin
        $display("ok   vec%0d outs=%b", i, outs());
      end
    end
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("retired_cnt_after_table", retired_cnt, 32'd6);
    chk("illegal_cnt_after_table", illegal_cnt, 32'd1);
`endif

    // Reset asserted during EXECUTE aborts the instruction.
    @(negedge clk); drive(0, 1, 4'd2, 5'd4, 0); #1;
    chk("abort_handshake", {31'd0, ir_load}, 32'd1);
    @(negedge clk); drive(0, 0, 4'd0, 5'd0, 0);
    @(negedge clk); #1;
    chk("abort_execute_alu", {29'd0, alu_en, alu_ctrl}, 32'h6);
    reset = 1'b1; #1;
    chk("abort_outs_zero", {18'd0, outs()}, 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("abort_counters_zero", retired_cnt | illegal_cnt, 32'd0);
`endif
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk("abort_hold_zero", {18'd0, outs()}, 32'd0);
    end
    @(negedge clk); reset = 1'b0; #1;
    chk("after_reset_ready", {18'd0, outs()}, 32'h2000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("after_reset_no_rw_pc", {29'd0, reg_write, pc_inc, busy}, 32'd0);
    end
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("after_reset_retired", retired_cnt, 32'd0);
`endif

    // Normal operation resumes after the abort.
    @(negedge clk); drive(0, 1, 4'd3, 5'd6, 0); #1;
    chk("resume_handshake", {31'd0, ir_load}, 32'd1);
    @(negedge clk); drive(0, 0, 4'd0, 5'd0, 0);
    @(negedge clk);
    @(negedge clk); #1;
    chk("resume_writeback", {24'd0, reg_write, pc_inc, alu_ctrl, 4'd0} | {27'd0, rf_waddr}, 32'hF6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
